multicycle_ctrl: RTL and testbench

Multi-cycle control unit that sequences the RV32I-subset datapath one instruction at a time. It steps through FETCH/DECODE/EXEC/MEM/WB states and drives the datapath's control strobes (`reg_write`, `alu_src`, `mem_to_reg`, `mem_read`, `mem_write`, `branch`, `alu_op`). It also drives `pc_write` and `ir_write`, and stalls on a memory ready handshake. It sits between the instruction register / ALU flags and the datapath control inputs, and replaces hand-driven control in benches.

---
 rtl/multicycle_ctrl_pkg.sv | 49 ++++
 rtl/multicycle_ctrl_if.sv | 29 ++
 rtl/multicycle_ctrl_alu_decoder.sv | 32 +++
 rtl/multicycle_ctrl.sv | 148 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit and its ALU decoder.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    function automatic logic [6:0] opcode_of(input logic [31:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control-unit side of the datapath: IR/flag inputs and the control strobes it drives.
interface multicycle_ctrl_if;
    import ctrl_pkg::*;

    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        pc_write;
    logic        ir_write;
    logic        reg_write;
    logic        alu_src;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    alu_op_t     alu_op;

    modport master (
        input  instr, zero, mem_ready,
        output pc_write, ir_write, reg_write, alu_src, mem_to_reg,
               mem_read, mem_write, branch, alu_op
    );

    modport slave (
        output instr, zero, mem_ready,
        input  pc_write, ir_write, reg_write, alu_src, mem_to_reg,
               mem_read, mem_write, branch, alu_op
    );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational opcode/funct3/funct7[5] to ALU function map; also used by the ALU bench.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output alu_op_t    alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        case (opcode)
            OP_R, OP_IALU: begin
                case (funct3)
                    // Only register-register ops have a SUB form; ADDI ignores bit 30.
                    F3_ADD_SUB: alu_op = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    F3_SLL:     alu_op = ALU_SLL;
                    F3_SLT:     alu_op = ALU_SLT;
                    F3_SLTU:    alu_op = ALU_SLTU;
                    F3_XOR:     alu_op = ALU_XOR;
                    F3_SRL_SRA: alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
                    F3_OR:      alu_op = ALU_OR;
                    F3_AND:     alu_op = ALU_AND;
                endcase
            end
            OP_BRANCH: alu_op = ALU_SUB;
            default:   alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I-subset control FSM. Define MULTICYCLE_CTRL_BRANCH_EN to support BEQ/BNE;
// otherwise branch opcodes trap and the branch strobe is tied low.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    multicycle_ctrl_if.master   ctrl,
    output logic                illegal,
    output logic [2:0]          state_o,
    output logic [RETIRE_W-1:0] retired
);

    state_t              state_reg, state_next;
    logic [RETIRE_W-1:0] retired_reg;
    logic                retire;

    logic [6:0] opcode;
    logic [2:0] funct3;
    alu_op_t    dec_op;
    logic       is_lw, is_sw, is_br, br_taken, is_legal;

    assign opcode = opcode_of(ctrl.instr);
    assign funct3 = ctrl.instr[14:12];
    assign is_lw  = (opcode == OP_LOAD)  && (funct3 == F3_LW);
    assign is_sw  = (opcode == OP_STORE) && (funct3 == F3_SW);

`ifdef MULTICYCLE_CTRL_BRANCH_EN
    assign is_br    = (opcode == OP_BRANCH) && ((funct3 == F3_BEQ) || (funct3 == F3_BNE));
    assign br_taken = ((funct3 == F3_BEQ) && ctrl.zero) || ((funct3 == F3_BNE) && !ctrl.zero);
    assign ctrl.branch = !reset && (state_reg == ST_EXEC) && is_br;
`else
    assign is_br       = 1'b0;
    assign br_taken    = 1'b0;
    assign ctrl.branch = 1'b0;
`endif

    assign is_legal = (opcode == OP_R) || (opcode == OP_IALU) || is_lw || is_sw || is_br;

    alu_decoder u_alu_decoder (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7_5 (ctrl.instr[30]),
        .alu_op   (dec_op)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_FETCH;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (retire) begin
                retired_reg <= retired_reg + RETIRE_W'(1);
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        retire          = 1'b0;
        ctrl.pc_write   = 1'b0;
        ctrl.ir_write   = 1'b0;
        ctrl.reg_write  = 1'b0;
        ctrl.alu_src    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
        ctrl.mem_read   = 1'b0;
        ctrl.mem_write  = 1'b0;
        ctrl.alu_op     = ALU_ADD;

        case (state_reg)
            ST_FETCH: begin
                ctrl.mem_read = 1'b1;
                if (ctrl.mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    state_next    = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_next = is_legal ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                ctrl.alu_op = dec_op;
                if (opcode == OP_R) begin
                    state_next = ST_WB;
                end else if (is_br) begin
                    ctrl.pc_write = br_taken;
                    state_next    = ST_FETCH;
                    retire        = 1'b1;
                end else if (opcode == OP_IALU) begin
                    ctrl.alu_src = 1'b1;
                    state_next   = ST_WB;
                end else begin
                    // Only LW/SW reach here: address = rs1 + imm.
                    ctrl.alu_src = 1'b1;
                    state_next   = ST_MEM;
                end
            end
            ST_MEM: begin
                if (is_lw) begin
                    ctrl.mem_read = 1'b1;
                    if (ctrl.mem_ready) begin
                        state_next = ST_WB;
                    end
                end else begin
                    ctrl.mem_write = 1'b1;
                    if (ctrl.mem_ready) begin
                        state_next = ST_FETCH;
                        retire     = 1'b1;
                    end
                end
            end
            ST_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = is_lw;
                state_next      = ST_FETCH;
                retire          = 1'b1;
            end
            ST_TRAP: begin
                state_next = ST_TRAP;
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase

        // Strobes are combinational, so they must be forced quiet while reset is held.
        if (reset) begin
            retire          = 1'b0;
            ctrl.pc_write   = 1'b0;
            ctrl.ir_write   = 1'b0;
            ctrl.reg_write  = 1'b0;
            ctrl.alu_src    = 1'b0;
            ctrl.mem_to_reg = 1'b0;
            ctrl.mem_read   = 1'b0;
            ctrl.mem_write  = 1'b0;
            ctrl.alu_op     = ALU_ADD;
        end
    end

    assign illegal = !reset && (state_reg == ST_TRAP);
    assign state_o = state_reg;
    assign retired = retired_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle vector table plus reset/branch/trap sequences.
module tb_multicycle_ctrl;

    localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, T = 3'd5;
    localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, SRA = 4'b0111, SLTU = 4'b1001;

    localparam logic [31:0] I_ADDI = 32'h00500113;
    localparam logic [31:0] I_LW   = 32'h00002183;
    localparam logic [31:0] I_SW   = 32'h00202023;
    localparam logic [31:0] I_SUB  = 32'h40218233;
    localparam logic [31:0] I_SRAI = 32'h4032D293;
    localparam logic [31:0] I_SLTU = 32'h0020B1B3;
    localparam logic [31:0] I_ADD  = 32'h00310233;
    localparam logic [31:0] I_BEQ  = 32'h00000063;
    localparam logic [31:0] I_BNE  = 32'h00001063;
    localparam logic [31:0] I_BLT  = 32'h00004063;
    localparam logic [31:0] I_LB   = 32'h00000183;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        illegal;
    logic [2:0]  state_o;
    logic [31:0] retired;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.RETIRE_W(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .ctrl    (bus.master),
        .illegal (illegal),
        .state_o (state_o),
        .retired (retired)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] instr;
        logic        rdy;
        logic [2:0]  st;
        logic [11:0] strb;
        logic [31:0] ret;
    } vec_t;

    vec_t tbl[28];

    // {pc_write, ir_write, reg_write, alu_src, mem_to_reg, mem_read, mem_write, branch, alu_op}
    function automatic logic [11:0] s(input logic pcw, input logic irw, input logic rw,
                                      input logic asrc, input logic m2r, input logic mr,
                                      input logic mw, input logic br, input logic [3:0] op);
        return {pcw, irw, rw, asrc, m2r, mr, mw, br, op};
    endfunction

    function automatic vec_t v(input logic [31:0] instr, input logic rdy, input logic [2:0] st,
                               input logic [11:0] strb, input logic [31:0] ret);
        vec_t r;
        r.instr = instr; r.rdy = rdy; r.st = st; r.strb = strb; r.ret = ret;
        return r;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check(input string tag, input logic [2:0] st, input logic [11:0] strb,
                         input logic [31:0] ret, input logic ill);
        logic [11:0] act_strb;
        act_strb = {bus.pc_write, bus.ir_write, bus.reg_write, bus.alu_src, bus.mem_to_reg,
                    bus.mem_read, bus.mem_write, bus.branch, bus.alu_op};
        $display("%s: state=%0d strobes=%03h retired=%0d illegal=%0b",
                 tag, state_o, act_strb, retired, illegal);
        cmp({tag, ".state"},   32'(state_o),  32'(st));
        cmp({tag, ".strobes"}, 32'(act_strb), 32'(strb));
        cmp({tag, ".retired"}, retired,       ret);
        cmp({tag, ".illegal"}, 32'(illegal),  32'(ill));
    endtask

    // Called at a falling edge: drive, settle, check, then wait past the next rising edge.
    task automatic run_cycle(input string tag, input logic [31:0] instr, input logic zero,
                             input logic rdy, input logic [2:0] st, input logic [11:0] strb,
                             input logic [31:0] ret, input logic ill);
        bus.instr     = instr;
        bus.zero      = zero;
        bus.mem_ready = rdy;
        #1;
        check(tag, st, strb, ret, ill);
        @(negedge clk);
    endtask

    initial begin
        logic [11:0] fetch_s, mr_s;
        fetch_s = s(1, 1, 0, 0, 0, 1, 0, 0, ADD);
        mr_s    = s(0, 0, 0, 0, 0, 1, 0, 0, ADD);

        tbl[0]  = v(I_ADDI, 1'b1, F, fetch_s, 0);
        tbl[1]  = v(I_ADDI, 1'b1, D, 12'h000, 0);
        tbl[2]  = v(I_ADDI, 1'b1, E, s(0, 0, 0, 1, 0, 0, 0, 0, ADD), 0);
        tbl[3]  = v(I_ADDI, 1'b1, W, s(0, 0, 1, 0, 0, 0, 0, 0, ADD), 0);
        tbl[4]  = v(I_LW,   1'b1, F, fetch_s, 1);
        tbl[5]  = v(I_LW,   1'b1, D, 12'h000, 1);
        tbl[6]  = v(I_LW,   1'b1, E, s(0, 0, 0, 1, 0, 0, 0, 0, ADD), 1);
        tbl[7]  = v(I_LW,   1'b0, M, mr_s, 1);
        tbl[8]  = v(I_LW,   1'b0, M, mr_s, 1);
        tbl[9]  = v(I_LW,   1'b1, M, mr_s, 1);
        tbl[10] = v(I_LW,   1'b1, W, s(0, 0, 1, 0, 1, 0, 0, 0, ADD), 1);
        tbl[11] = v(I_SW,   1'b1, F, fetch_s, 2);
        tbl[12] = v(I_SW,   1'b1, D, 12'h000, 2);
        tbl[13] = v(I_SW,   1'b1, E, s(0, 0, 0, 1, 0, 0, 0, 0, ADD), 2);
        tbl[14] = v(I_SW,   1'b1, M, s(0, 0, 0, 0, 0, 0, 1, 0, ADD), 2);
        tbl[15] = v(I_SUB,  1'b0, F, mr_s, 3);
        tbl[16] = v(I_SUB,  1'b1, F, fetch_s, 3);
        tbl[17] = v(I_SUB,  1'b1, D, 12'h000, 3);
        tbl[18] = v(I_SUB,  1'b1, E, s(0, 0, 0, 0, 0, 0, 0, 0, SUB), 3);
        tbl[19] = v(I_SUB,  1'b1, W, s(0, 0, 1, 0, 0, 0, 0, 0, ADD), 3);
        tbl[20] = v(I_SRAI, 1'b1, F, fetch_s, 4);
        tbl[21] = v(I_SRAI, 1'b0, D, 12'h000, 4);
        tbl[22] = v(I_SRAI, 1'b1, E, s(0, 0, 0, 1, 0, 0, 0, 0, SRA), 4);
        tbl[23] = v(I_SRAI, 1'b0, W, s(0, 0, 1, 0, 0, 0, 0, 0, ADD), 4);
        tbl[24] = v(I_SLTU, 1'b1, F, fetch_s, 5);
        tbl[25] = v(I_SLTU, 1'b1, D, 12'h000, 5);
        tbl[26] = v(I_SLTU, 1'b1, E, s(0, 0, 0, 0, 0, 0, 0, 0, SLTU), 5);
        tbl[27] = v(I_SLTU, 1'b1, W, s(0, 0, 1, 0, 0, 0, 0, 0, ADD), 5);

        bus.instr     = I_ADDI;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        check("reset_hold", F, 12'h000, 0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 28; i++) begin
            run_cycle($sformatf("vec%0d", i), tbl[i].instr, 1'b0, tbl[i].rdy,
                      tbl[i].st, tbl[i].strb, tbl[i].ret, 1'b0);
        end

        // Reset asserted in the EXEC cycle of ADD aborts it without retiring.
        run_cycle("add.fetch",  I_ADD, 1'b0, 1'b1, F, fetch_s, 6, 1'b0);
        run_cycle("add.decode", I_ADD, 1'b0, 1'b1, D, 12'h000, 6, 1'b0);
        #1;
        check("add.exec", E, 12'h000, 6, 1'b0);
        reset = 1'b1;
        #1;
        check("add.reset_now", F, 12'h000, 0, 1'b0);
        @(negedge clk);
        check("add.reset_held", F, 12'h000, 0, 1'b0);
        reset = 1'b0;
        run_cycle("add.refetch", I_ADD, 1'b0, 1'b1, F, fetch_s, 0, 1'b0);
        run_cycle("add.decode2", I_ADD, 1'b0, 1'b1, D, 12'h000, 0, 1'b0);
        run_cycle("add.exec2",   I_ADD, 1'b0, 1'b1, E, 12'h000, 0, 1'b0);
        run_cycle("add.wb",      I_ADD, 1'b0, 1'b1, W, s(0, 0, 1, 0, 0, 0, 0, 0, ADD), 0, 1'b0);

`ifdef MULTICYCLE_CTRL_BRANCH_EN
        run_cycle("beq1.fetch",  I_BEQ, 1'b0, 1'b1, F, fetch_s, 1, 1'b0);
        run_cycle("beq1.decode", I_BEQ, 1'b0, 1'b1, D, 12'h000, 1, 1'b0);
        run_cycle("beq1.exec",   I_BEQ, 1'b1, 1'b1, E, s(1, 0, 0, 0, 0, 0, 0, 1, SUB), 1, 1'b0);
        run_cycle("beq0.fetch",  I_BEQ, 1'b0, 1'b1, F, fetch_s, 2, 1'b0);
        run_cycle("beq0.decode", I_BEQ, 1'b1, 1'b1, D, 12'h000, 2, 1'b0);
        run_cycle("beq0.exec",   I_BEQ, 1'b0, 1'b1, E, s(0, 0, 0, 0, 0, 0, 0, 1, SUB), 2, 1'b0);
        run_cycle("bne.fetch",   I_BNE, 1'b0, 1'b1, F, fetch_s, 3, 1'b0);
        run_cycle("bne.decode",  I_BNE, 1'b0, 1'b1, D, 12'h000, 3, 1'b0);
        run_cycle("bne.exec",    I_BNE, 1'b0, 1'b1, E, s(1, 0, 0, 0, 0, 0, 0, 1, SUB), 3, 1'b0);
        run_cycle("blt.fetch",   I_BLT, 1'b0, 1'b1, F, fetch_s, 4, 1'b0);
        run_cycle("blt.decode",  I_BLT, 1'b0, 1'b1, D, 12'h000, 4, 1'b0);
        run_cycle("blt.trap",    I_BLT, 1'b1, 1'b1, T, 12'h000, 4, 1'b1);
        run_cycle("blt.trap2",   I_BLT, 1'b0, 1'b0, T, 12'h000, 4, 1'b1);
`else
        run_cycle("beq.fetch",  I_BEQ, 1'b0, 1'b1, F, fetch_s, 1, 1'b0);
        run_cycle("beq.decode", I_BEQ, 1'b1, 1'b1, D, 12'h000, 1, 1'b0);
        run_cycle("beq.trap",   I_BEQ, 1'b1, 1'b1, T, 12'h000, 1, 1'b1);
        run_cycle("beq.trap2",  I_BEQ, 1'b0, 1'b0, T, 12'h000, 1, 1'b1);
        run_cycle("beq.trap3",  I_ADDI, 1'b0, 1'b1, T, 12'h000, 1, 1'b1);
`endif

        // Only reset leaves TRAP.
        reset = 1'b1;
        #1;
        check("trap.reset", F, 12'h000, 0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        run_cycle("lb.fetch",  I_LB, 1'b0, 1'b1, F, fetch_s, 0, 1'b0);
        run_cycle("lb.decode", I_LB, 1'b0, 1'b1, D, 12'h000, 0, 1'b0);
        run_cycle("lb.trap",   I_LB, 1'b0, 1'b1, T, 12'h000, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
